sd_responder: RTL and testbench
===============================

SD_RESPONDER -- requirements
Module: sd_responder

Interface
REQ-001 Parameter DEPTH, 8, command FIFO entries (power of two, 4..16).
REQ-002 Parameter RD_LAT, 2, cycles from mem_re to valid mem_rd_data (1..4).
REQ-003 Parameter REF_INT, 780, cycles between refresh requests.
REQ-004 Parameter REF_CYC, 8, cycles a refresh blocks the memory port.
REQ-005 Ports, in this order:
- clk  in  1  sole clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- sd_addr  in  25  word address from master.
- sd_byte_en_n  in  2  active-low byte enables.
- sd_data  in  16  write data.
- sd_read_n  in  1  active-low read strobe.
- sd_write_n  in  1  active-low write strobe.
- sd_wait_rq  out  1  stall; master holds its command while high.
- sd_rd_data  out  16  read return data.
- sd_rd_valid  out  1  one-cycle qualifier per returned read word.
- mem_addr  out  22  memory word address.
- mem_wr_data  out  16  memory write data.
- mem_be  out  2  active-high byte enables.
- mem_we  out  1  one-cycle write strobe.
- mem_re  out  1  one-cycle read strobe.
- mem_rd_data  in  16  memory read data, valid RD_LAT cycles after mem_re.
- mem_busy  in  1  memory not ready; no strobe may issue while high.
- mem_ref  out  1  high during refresh window.
- err_addr  out  1  sticky out-of-range address flag.
- proto_err  out  1  sticky flag, both strobes low together.
- cmd_count  out  5  current FIFO occupancy.

Function
REQ-006 Command accepted on a rising edge where (~sd_read_n | ~sd_write_n) & ~sd_wait_rq; the entry pushes {type, addr, data, ~sd_byte_en_n}.
REQ-007 Both strobes low on an accepted cycle: treated as write; proto_err set.
REQ-008 sd_wait_rq is registered: next value = (occupancy after this edge >= DEPTH-1); max occupancy DEPTH-1, so the FIFO never overflows.
REQ-009 Simultaneous push and pop leave occupancy unchanged; cmd_count tracks occupancy exactly.
REQ-010 Issue FSM states: IDLE, ISSUE, REFRESH.
- IDLE -> ISSUE when FIFO not empty, no refresh pending, and mem_busy low.
- ISSUE: pop the head; drive mem_we or mem_re high for exactly one cycle together with mem_addr = addr[21:0], mem_wr_data and mem_be.
- ISSUE -> ISSUE while more entries remain and the conditions hold (one command per cycle max); otherwise -> IDLE.
- Pending refresh: any state -> REFRESH after the current issue cycle; mem_ref high for exactly REF_CYC cycles; then -> IDLE.
REQ-011 Refresh counter counts 0..REF_INT-1 continuously and sets a pending flag on wrap; the flag clears on REFRESH entry; a wrap while already pending is not queued twice.
REQ-012 mem_busy high: no strobes issue, FIFO entries are held, and the refresh counter keeps counting.
REQ-013 Read return: a tag shift register RD_LAT deep captures mem_rd_data; sd_rd_valid pulses exactly RD_LAT+1 cycles after the mem_re cycle, with sd_rd_data registered.
REQ-014 Read data returns in issue order, with one valid per accepted read.
REQ-015 Entry with addr[24:22] != 0:
- set err_addr;
- a write issues no strobe;
- a read issues no mem_re but still returns sd_rd_valid with sd_rd_data = 0 at the same latency as a normal read.
REQ-016 mem_be = ~sd_byte_en_n as captured; a write with mem_be = 0 still issues mem_we.

Reset
REQ-017 In any reset cycle:
- sd_wait_rq = 1;
- sd_rd_valid, mem_we, mem_re, mem_ref, err_addr, proto_err = 0;
- cmd_count = 0; sd_rd_data, mem_addr, mem_wr_data, mem_be = 0;
- FSM = IDLE; refresh counter = 0; pending flag cleared.
REQ-018 sd_wait_rq falls on the first edge after reset deasserts.
REQ-019 Reset mid-operation discards FIFO contents and in-flight reads; no sd_rd_valid appears after reset for reads issued before it.

Verification
REQ-020 Write 0x00A5 to 0x000123, byte_en_n = 0 -> mem_we pulse with mem_addr 0x000123, mem_wr_data 0x00A5, mem_be 2'b11.
REQ-021 Read 0x000123 with the memory model returning 0xBEEF, RD_LAT 2 -> sd_rd_valid with 0xBEEF exactly 3 cycles after the mem_re cycle.
REQ-022 mem_busy held high while 10 writes are offered back-to-back -> sd_wait_rq rises when cmd_count reaches 7, no loss; release mem_busy -> 10 mem_we pulses in order.
REQ-023 Read to 0x0800000 -> err_addr = 1, no mem_re, sd_rd_valid with 0x0000.
REQ-024 REF_INT 16, REF_CYC 8 with continuous reads -> mem_ref high 8 cycles every 16, no strobe during the window, all reads returned in order.
REQ-025 Reset asserted with 3 reads in flight -> no sd_rd_valid afterwards; cmd_count = 0; sd_wait_rq = 1 during reset.

Source files
------------

// File: rtl/sd_responder.sv
// SDRAM-style front end: queues master commands in a small FIFO, issues at most one per
// cycle to a memory port, returns read data at fixed latency and inserts refresh windows.
module sd_responder #(
    parameter int DEPTH   = 8,
    parameter int RD_LAT  = 2,
    parameter int REF_INT = 780,
    parameter int REF_CYC = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [24:0] sd_addr,
    input  logic [1:0]  sd_byte_en_n,
    input  logic [15:0] sd_data,
    input  logic        sd_read_n,
    input  logic        sd_write_n,
    output logic        sd_wait_rq,
    output logic [15:0] sd_rd_data,
    output logic        sd_rd_valid,
    output logic [21:0] mem_addr,
    output logic [15:0] mem_wr_data,
    output logic [1:0]  mem_be,
    output logic        mem_we,
    output logic        mem_re,
    input  logic [15:0] mem_rd_data,
    input  logic        mem_busy,
    output logic        mem_ref,
    output logic        err_addr,
    output logic        proto_err,
    output logic [4:0]  cmd_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int TW = (REF_INT > 1) ? $clog2(REF_INT) : 1;
    localparam int CW = $clog2(REF_CYC + 1);

    typedef struct packed {
        logic        wr;
        logic [24:0] addr;
        logic [15:0] data;
        logic [1:0]  be;
    } cmd_t;

    typedef enum logic [1:0] {IDLE, ISSUE, REFRESH} state_t;

    cmd_t              fifo_mem [DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [4:0]        count, count_nxt;
    cmd_t              head, push_cmd;
    logic              push, pop, head_err;

    state_t            state, state_nxt;
    logic [TW-1:0]     ref_timer;
    logic              ref_wrap, ref_pend, enter_ref;
    logic [CW-1:0]     ref_cyc_cnt;

    logic [RD_LAT:0]   vld_pipe;
    logic [RD_LAT-1:0] err_pipe;
    logic              rd_issue;

    // Both strobes low is taken as a write.
    assign push      = (~sd_read_n | ~sd_write_n) & ~sd_wait_rq;
    assign push_cmd  = {~sd_write_n, sd_addr, sd_data, ~sd_byte_en_n};
    assign head      = fifo_mem[rd_ptr];
    assign head_err  = |head.addr[24:22];
    assign count_nxt = count + {4'd0, push} - {4'd0, pop};
    assign cmd_count = count;

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= push_cmd;
    end

    // Wait is raised one entry early so a held command can never overflow the FIFO.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            sd_wait_rq <= 1'b1;
            err_addr   <= 1'b0;
            proto_err  <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count      <= count_nxt;
            sd_wait_rq <= (count_nxt >= 5'(DEPTH - 1));
            if (push && (|sd_addr[24:22]))     err_addr  <= 1'b1;
            if (push && !sd_read_n && !sd_write_n) proto_err <= 1'b1;
        end
    end

    assign ref_wrap = (ref_timer == TW'(REF_INT - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            ref_timer <= '0;
            ref_pend  <= 1'b0;
        end else begin
            ref_timer <= ref_wrap ? '0 : ref_timer + TW'(1);
            if (enter_ref)     ref_pend <= 1'b0;
            else if (ref_wrap) ref_pend <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            ref_cyc_cnt <= '0;
        end else begin
            state       <= state_nxt;
            ref_cyc_cnt <= (state == REFRESH) ? ref_cyc_cnt + CW'(1) : '0;
        end
    end

    // A late mem_busy in ISSUE suppresses the pop; the entry stays at the head.
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                if (ref_pend)                         state_nxt = REFRESH;
                else if (count != 5'd0 && !mem_busy)  state_nxt = ISSUE;
            end
            ISSUE: begin
                pop = (count != 5'd0) && !mem_busy;
                if (ref_pend)                                        state_nxt = REFRESH;
                else if (pop && (count + {4'd0, push} != 5'd1))      state_nxt = ISSUE;
                else                                                 state_nxt = IDLE;
            end
            REFRESH: begin
                if (ref_cyc_cnt == CW'(REF_CYC - 1)) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign enter_ref = (state != REFRESH) && (state_nxt == REFRESH);

    // Out-of-range entries are consumed without a strobe; reads still get a return slot.
    assign rd_issue    = pop & ~head.wr;
    assign mem_we      = pop & head.wr & ~head_err;
    assign mem_re      = rd_issue & ~head_err;
    assign mem_addr    = pop ? head.addr[21:0] : '0;
    assign mem_wr_data = pop ? head.data : '0;
    assign mem_be      = pop ? head.be : '0;
    assign mem_ref     = (state == REFRESH);

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_pipe   <= '0;
            err_pipe   <= '0;
            sd_rd_data <= '0;
        end else begin
            vld_pipe    <= {vld_pipe[RD_LAT-1:0], rd_issue};
            err_pipe[0] <= head_err;
            for (int i = 1; i < RD_LAT; i++) err_pipe[i] <= err_pipe[i-1];
            if (vld_pipe[RD_LAT-1]) sd_rd_data <= err_pipe[RD_LAT-1] ? 16'h0000 : mem_rd_data;
        end
    end

    assign sd_rd_valid = vld_pipe[RD_LAT];

endmodule

// File: tb/tb_sd_responder.sv
// Scoreboard bench for sd_responder with a fixed-latency read-only memory model.
`timescale 1ns/1ps
module tb_sd_responder;
    localparam int RD_LAT  = 2;
    localparam int REF_INT = 16;
    localparam int REF_CYC = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [24:0] sd_addr;
    logic [1:0]  sd_byte_en_n;
    logic [15:0] sd_data;
    logic        sd_read_n, sd_write_n;
    logic        sd_wait_rq;
    logic [15:0] sd_rd_data;
    logic        sd_rd_valid;
    logic [21:0] mem_addr;
    logic [15:0] mem_wr_data;
    logic [1:0]  mem_be;
    logic        mem_we, mem_re;
    logic [15:0] mem_rd_data;
    logic        mem_busy;
    logic        mem_ref;
    logic        err_addr, proto_err;
    logic [4:0]  cmd_count;

    sd_responder #(.DEPTH(8), .RD_LAT(RD_LAT), .REF_INT(REF_INT), .REF_CYC(REF_CYC)) dut (
        .clk(clk), .reset(reset), .sd_addr(sd_addr), .sd_byte_en_n(sd_byte_en_n),
        .sd_data(sd_data), .sd_read_n(sd_read_n), .sd_write_n(sd_write_n),
        .sd_wait_rq(sd_wait_rq), .sd_rd_data(sd_rd_data), .sd_rd_valid(sd_rd_valid),
        .mem_addr(mem_addr), .mem_wr_data(mem_wr_data), .mem_be(mem_be),
        .mem_we(mem_we), .mem_re(mem_re), .mem_rd_data(mem_rd_data), .mem_busy(mem_busy),
        .mem_ref(mem_ref), .err_addr(err_addr), .proto_err(proto_err), .cmd_count(cmd_count)
    );

    always #5 clk = ~clk;

    int          n_chk = 0, n_err = 0, cyc = 0;
    logic [39:0] wr_q [$];
    logic [16:0] rd_q [$];
    logic [21:0] ra_q [$];
    int          lat_q [$];
    int          last_rise = -1, ref_run = 0;
    logic        ref_d = 1'b0;
    logic [16:0] rd_e;
    logic        rnd_done;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic logic [15:0] mem_f(input logic [21:0] a);
        return (a == 22'h000123) ? 16'hBEEF : (a[15:0] ^ 16'hC3A5);
    endfunction

    // Memory: data for the address strobed in cycle C is presented during cycle C+2.
    logic [21:0] ma1 = '0, ma2 = '0;
    always @(posedge clk) begin
        ma1 <= mem_addr;
        ma2 <= ma1;
        cyc <= cyc + 1;
    end
    assign mem_rd_data = mem_f(ma2);

    always @(negedge clk) begin
        if (reset) begin
            wr_q.delete(); rd_q.delete(); ra_q.delete(); lat_q.delete();
            last_rise = -1; ref_run = 0; ref_d = 1'b0;
        end else begin
            if (mem_we || mem_re) begin
                chk("strb_in_ref", mem_ref, 0);
                chk("strb_busy", mem_busy, 0);
                chk("strb_both", mem_we & mem_re, 0);
            end
            if (mem_we) begin
                chk("wr_expected", wr_q.size() != 0, 1);
                if (wr_q.size() != 0) chk("wr_cmd", {mem_addr, mem_wr_data, mem_be}, wr_q.pop_front());
            end
            if (mem_re) begin
                chk("re_expected", ra_q.size() != 0, 1);
                if (ra_q.size() != 0) chk("re_addr", mem_addr, ra_q.pop_front());
                lat_q.push_back(cyc);
            end
            if (sd_rd_valid) begin
                chk("rv_expected", rd_q.size() != 0, 1);
                if (rd_q.size() != 0) begin
                    rd_e = rd_q.pop_front();
                    chk("rd_data", sd_rd_data, rd_e[15:0]);
                    if (!rd_e[16]) begin
                        chk("rd_lat_tag", lat_q.size() != 0, 1);
                        if (lat_q.size() != 0) chk("rd_lat", cyc - lat_q.pop_front(), RD_LAT + 1);
                    end
                end
            end
            if (mem_ref && !ref_d) begin
                if (last_rise >= 0) chk("ref_period", cyc - last_rise, REF_INT);
                last_rise = cyc;
                ref_run   = 0;
            end
            if (mem_ref) ref_run++;
            if (!mem_ref && ref_d) chk("ref_len", ref_run, REF_CYC);
            ref_d = mem_ref;
        end
    end

    task automatic step(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send(input logic rd_n, input logic wr_n, input logic [24:0] a,
                        input logic [15:0] d, input logic [1:0] ben);
        int n = 0;
        sd_read_n = rd_n; sd_write_n = wr_n; sd_addr = a; sd_data = d; sd_byte_en_n = ben;
        while (sd_wait_rq && n < 300) begin @(posedge clk); #1; n++; end
        if (n >= 300) chk("accept_tmo", sd_wait_rq, 0);
        else begin
            if (a[24:22] == 3'd0) begin
                if (!wr_n) wr_q.push_back({a[21:0], d, ~ben});
                else       ra_q.push_back(a[21:0]);
            end
            if (wr_n) rd_q.push_back((a[24:22] != 3'd0) ? 17'h10000 : {1'b0, mem_f(a[21:0])});
        end
        @(posedge clk); #1;
        sd_read_n = 1'b1; sd_write_n = 1'b1;
    endtask

    task automatic drain();
        int n = 0;
        while ((cmd_count != 0 || rd_q.size() != 0 || wr_q.size() != 0) && n < 500) begin
            @(posedge clk); #1; n++;
        end
        chk("drain", (cmd_count == 0) && (rd_q.size() == 0) && (wr_q.size() == 0), 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        logic [2:0] hi;
        sd_addr = '0; sd_data = '0; sd_byte_en_n = 2'b11;
        sd_read_n = 1'b1; sd_write_n = 1'b1; mem_busy = 1'b0; rnd_done = 1'b0;
        reset = 1'b1;
        step(3);
        chk("rst_wait", sd_wait_rq, 1);
        chk("rst_rvalid", sd_rd_valid, 0);
        chk("rst_we", mem_we, 0);
        chk("rst_re", mem_re, 0);
        chk("rst_ref", mem_ref, 0);
        chk("rst_erra", err_addr, 0);
        chk("rst_proto", proto_err, 0);
        chk("rst_cnt", cmd_count, 0);
        chk("rst_rdata", sd_rd_data, 0);
        chk("rst_mem_out", {mem_addr, mem_wr_data, mem_be}, 0);
        reset = 1'b0;
        step(1);
        chk("wait_fall", sd_wait_rq, 0);

        // basic write and read-back latency
        send(1'b1, 1'b0, 25'h000123, 16'h00A5, 2'b00);
        drain();
        send(1'b0, 1'b1, 25'h000123, 16'h0000, 2'b00);
        drain();

        // byte-enable variants, including all lanes disabled
        send(1'b1, 1'b0, 25'h000045, 16'h1111, 2'b11);
        send(1'b1, 1'b0, 25'h000046, 16'h2222, 2'b01);
        send(1'b1, 1'b0, 25'h000047, 16'h3333, 2'b10);
        drain();

        // out-of-range read and write
        chk("erra_pre", err_addr, 0);
        send(1'b0, 1'b1, 25'h0800000, 16'h0000, 2'b00);
        send(1'b1, 1'b0, 25'h1C00010, 16'hDEAD, 2'b00);
        send(1'b0, 1'b1, 25'h0000050, 16'h0000, 2'b00);
        drain();
        chk("erra_set", err_addr, 1);

        // both strobes low
        chk("proto_pre", proto_err, 0);
        send(1'b0, 1'b0, 25'h000077, 16'h1234, 2'b00);
        drain();
        chk("proto_set", proto_err, 1);

        // backpressure with the memory stalled
        mem_busy = 1'b1;
        fork
            begin : bp_send
                for (int i = 0; i < 10; i++) send(1'b1, 1'b0, 25'h200 + i, 16'h1000 + 16'(i), 2'b00);
            end
            begin : bp_watch
                int n;
                n = 0;
                while (!sd_wait_rq && n < 100) begin @(posedge clk); #1; n++; end
                chk("wait_rise", sd_wait_rq, 1);
                chk("cnt_at_wait", cmd_count, 7);
                step(5);
                chk("cnt_hold", cmd_count, 7);
                mem_busy = 1'b0;
            end
        join
        drain();

        // continuous reads across refresh windows
        fork
            begin : ref_send
                for (int i = 0; i < 24; i++) send(1'b0, 1'b1, 25'h300 + i, 16'h0000, 2'b00);
            end
            begin : ref_duty
                cnt = 0;
                repeat (32) begin @(posedge clk); #1; cnt += int'(mem_ref); end
                chk("ref_duty", cnt, 16);
            end
        join
        drain();

        // random mix with a stuttering memory
        fork
            begin : rnd_send
                for (int i = 0; i < 40; i++) begin
                    hi = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
                    if ($urandom_range(0, 1) == 1)
                        send(1'b1, 1'b0, {hi, 22'($urandom)}, 16'($urandom), 2'($urandom));
                    else
                        send(1'b0, 1'b1, {hi, 22'($urandom)}, 16'h0000, 2'b00);
                end
                rnd_done = 1'b1;
            end
            begin : rnd_busy
                while (!rnd_done) begin
                    mem_busy = ($urandom_range(0, 3) == 0);
                    step(1);
                end
                mem_busy = 1'b0;
            end
        join
        drain();

        // reset with reads in flight
        send(1'b0, 1'b1, 25'h000400, 16'h0000, 2'b00);
        send(1'b0, 1'b1, 25'h000401, 16'h0000, 2'b00);
        send(1'b0, 1'b1, 25'h000402, 16'h0000, 2'b00);
        step(1);
        reset = 1'b1;
        step(1);
        chk("rst2_wait", sd_wait_rq, 1);
        chk("rst2_cnt", cmd_count, 0);
        chk("rst2_rvalid", sd_rd_valid, 0);
        step(2);
        reset = 1'b0;
        cnt = 0;
        repeat (12) begin @(posedge clk); #1; cnt += int'(sd_rd_valid); end
        chk("post_rst_valid", cnt, 0);
        chk("post_rst_cnt", cmd_count, 0);
        chk("post_rst_erra", err_addr, 0);

        // operation resumes after reset
        send(1'b1, 1'b0, 25'h000500, 16'h5A5A, 2'b00);
        send(1'b0, 1'b1, 25'h000500, 16'h0000, 2'b00);
        drain();
        chk("left_ra", ra_q.size(), 0);
        chk("left_lat", lat_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
